// File: rtl/guess_checker_pkg.sv
// rtl/guess_checker_pkg.sv - shared constants, FSM states and helpers for guess_checker
package guess_pkg;

    localparam int NUM_POS    = 4;
    localparam int COLOR_W    = 3;
    localparam int NUM_COLORS = 8;

    // Fibonacci taps 16,14,13,11 -> bits 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXACT = 2'd1,
        COLOR = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [2:0] color_count(
        input logic [NUM_POS-1:0][COLOR_W-1:0] v,
        input logic [COLOR_W-1:0]              c
    );
        logic [2:0] n;
        n = '0;
        for (int p = 0; p < NUM_POS; p++) begin
            n = n + {2'b00, (v[p] == c)};
        end
        return n;
    endfunction

endpackage

// File: rtl/guess_checker_lfsr16.sv
// rtl/guess_checker_lfsr16.sv - free-running 16-bit Fibonacci LFSR
module lfsr16
    import guess_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= SEED;
        end else begin
            q <= {q[14:0], ^(q & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/guess_checker.sv
// rtl/guess_checker.sv - secret holder and sequential exact/partial scorer with game state
module guess_checker
    import guess_pkg::*;
#(
    parameter int          MAX_ATTEMPTS = 8,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        new_game,
    input  logic        secret_load,
    input  logic [11:0] secret_in,
    input  logic        submit,
    input  logic [2:0]  guess_zero,
    input  logic [2:0]  guess_one,
    input  logic [2:0]  guess_two,
    input  logic [2:0]  guess_three,
    output logic        busy,
    output logic        result_valid,
    output logic [2:0]  exact_cnt,
    output logic [2:0]  partial_cnt,
    output logic [3:0]  attempts,
    output logic        win,
    output logic        lose,
    output logic        game_active
);

    localparam logic [3:0] MAX_A = 4'(MAX_ATTEMPTS);

    state_t                            state;
    logic [2:0]                        idx;
    logic [NUM_POS-1:0][COLOR_W-1:0]   secret;
    logic [NUM_POS-1:0][COLOR_W-1:0]   guess_q;
    logic [2:0]                        exact_acc;
    logic [2:0]                        total_acc;
    logic [15:0]                       lfsr_q;

    logic [2:0] g_cnt;
    logic [2:0] s_cnt;
    logic [2:0] min_cnt;
    logic [3:0] attempts_next;
    logic       win_next;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (lfsr_q)
    );

    always_comb begin
        g_cnt         = color_count(guess_q, idx);
        s_cnt         = color_count(secret, idx);
        min_cnt       = (g_cnt < s_cnt) ? g_cnt : s_cnt;
        attempts_next = attempts + 4'd1;
        win_next      = (exact_acc == 3'd4);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            idx          <= '0;
            secret       <= '0;
            guess_q      <= '0;
            exact_acc    <= '0;
            total_acc    <= '0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            exact_cnt    <= '0;
            partial_cnt  <= '0;
            attempts     <= '0;
            win          <= 1'b0;
            lose         <= 1'b0;
            game_active  <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            if (new_game) begin
                // Also aborts any evaluation in flight
                secret      <= secret_load ? secret_in : lfsr_q[11:0];
                attempts    <= '0;
                win         <= 1'b0;
                lose        <= 1'b0;
                exact_cnt   <= '0;
                partial_cnt <= '0;
                game_active <= 1'b1;
                busy        <= 1'b0;
                state       <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        busy <= 1'b0;
                        if (submit && game_active) begin
                            guess_q   <= {guess_three, guess_two, guess_one, guess_zero};
                            idx       <= '0;
                            exact_acc <= '0;
                            total_acc <= '0;
                            busy      <= 1'b1;
                            state     <= EXACT;
                        end
                    end
                    EXACT: begin
                        if (guess_q[idx[1:0]] == secret[idx[1:0]]) begin
                            exact_acc <= exact_acc + 3'd1;
                        end
                        idx <= (idx == 3'd3) ? 3'd0 : idx + 3'd1;
                        if (idx == 3'd3) begin
                            state <= COLOR;
                        end
                    end
                    COLOR: begin
                        total_acc <= total_acc + min_cnt;
                        idx       <= idx + 3'd1;
                        if (idx == 3'd7) begin
                            state <= DONE;
                        end
                    end
                    DONE: begin
                        // busy stays high through the result_valid cycle
                        exact_cnt    <= exact_acc;
                        partial_cnt  <= total_acc - exact_acc;
                        attempts     <= attempts_next;
                        win          <= win_next;
                        lose         <= !win_next && (attempts_next == MAX_A);
                        if (win_next || (attempts_next == MAX_A)) begin
                            game_active <= 1'b0;
                        end
                        result_valid <= 1'b1;
                        state        <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_guess_checker.sv
// tb/tb_guess_checker.sv - scoreboard bench for guess_checker
module tb_guess_checker;

    logic        clk;
    logic        rst_n;
    logic        new_game;
    logic        secret_load;
    logic [11:0] secret_in;
    logic        submit;
    logic [2:0]  guess_zero, guess_one, guess_two, guess_three;
    logic        busy, result_valid, win, lose, game_active;
    logic [2:0]  exact_cnt, partial_cnt;
    logic [3:0]  attempts;

    int checks   = 0;
    int failures = 0;
    int rv_count = 0;
    logic [5:0]  exp_q[$];
    logic [15:0] m_lfsr;

    guess_checker #(.MAX_ATTEMPTS(3), .LFSR_SEED(16'hACE1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .new_game     (new_game),
        .secret_load  (secret_load),
        .secret_in    (secret_in),
        .submit       (submit),
        .guess_zero   (guess_zero),
        .guess_one    (guess_one),
        .guess_two    (guess_two),
        .guess_three  (guess_three),
        .busy         (busy),
        .result_valid (result_valid),
        .exact_cnt    (exact_cnt),
        .partial_cnt  (partial_cnt),
        .attempts     (attempts),
        .win          (win),
        .lose         (lose),
        .game_active  (game_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Mastermind score by marking matched pegs
    function automatic logic [5:0] score(input logic [11:0] s, input logic [11:0] g);
        logic [3:0] us, ug;
        logic [2:0] ex, pa;
        logic       hit;
        us = '0; ug = '0; ex = '0; pa = '0;
        for (int p = 0; p < 4; p++) begin
            if (g[3*p +: 3] == s[3*p +: 3]) begin
                ex = ex + 3'd1; us[p] = 1'b1; ug[p] = 1'b1;
            end
        end
        for (int p = 0; p < 4; p++) begin
            hit = 1'b0;
            for (int q = 0; q < 4; q++) begin
                if (!ug[p] && !us[q] && !hit && g[3*p +: 3] == s[3*q +: 3]) begin
                    us[q] = 1'b1; hit = 1'b1; pa = pa + 3'd1;
                end
            end
        end
        return {ex, pa};
    endfunction

    always @(negedge clk) begin
        if (rst_n && result_valid) begin
            logic [5:0] e;
            rv_count++;
            if (exp_q.size() == 0) begin
                check("rv_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("exact_cnt", exact_cnt, e[5:3]);
                check("partial_cnt", partial_cnt, e[2:0]);
            end
        end
    end

    task automatic start_game(input logic load, input logic [11:0] sec, output logic [11:0] used);
        new_game = 1'b1; secret_load = load; secret_in = sec;
        used = load ? sec : m_lfsr[11:0];
        @(negedge clk);
        new_game = 1'b0; secret_load = 1'b0;
        check("ng_game_active", game_active, 1);
        check("ng_attempts", attempts, 0);
        check("ng_busy", busy, 0);
        check("ng_win_lose", {win, lose}, 0);
    endtask

    task automatic do_guess(input logic [11:0] g, input logic accept, input logic [11:0] sec);
        int n;
        {guess_three, guess_two, guess_one, guess_zero} = g;
        submit = 1'b1;
        if (accept) exp_q.push_back(score(sec, g));
        @(negedge clk);
        submit = 1'b0;
        check("busy_after_submit", busy, accept);
        if (accept) begin
            n = 0;
            while (n < 20 && !result_valid) begin
                @(negedge clk);
                n++;
            end
            check("latency", n, 13);
            check("busy_in_rv_cycle", busy, 1);
            @(negedge clk);
            check("busy_after_rv", busy, 0);
        end else begin
            repeat (16) @(negedge clk);
            check("dropped_busy", busy, 0);
        end
    endtask

    initial begin
        logic [11:0] s, g, g2;
        logic [5:0]  r;
        int          rv0;
        logic [3:0]  a0;

        rst_n = 1'b0; new_game = 0; secret_load = 0; secret_in = 0; submit = 0;
        guess_zero = 0; guess_one = 0; guess_two = 0; guess_three = 0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {busy, result_valid, exact_cnt, partial_cnt, attempts, win, lose, game_active}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_guess(12'h000, 1'b0, 12'h000);
        check("pregame_attempts", attempts, 0);

        start_game(1'b1, {3'd4, 3'd3, 3'd2, 3'd1}, s);
        do_guess({3'd4, 3'd3, 3'd2, 3'd1}, 1'b1, s);
        check("full_win", win, 1);
        check("full_game_active", game_active, 0);
        check("full_attempts", attempts, 1);
        check("full_lose", lose, 0);
        do_guess(12'h000, 1'b0, s);

        start_game(1'b1, {3'd4, 3'd3, 3'd2, 3'd1}, s);
        do_guess({3'd1, 3'd2, 3'd3, 3'd4}, 1'b1, s);
        check("misplaced_win", win, 0);
        check("misplaced_active", game_active, 1);

        start_game(1'b1, {3'd2, 3'd2, 3'd1, 3'd1}, s);
        do_guess({3'd1, 3'd1, 3'd2, 3'd1}, 1'b1, s);

        start_game(1'b1, {3'd4, 3'd3, 3'd2, 3'd1}, s);
        do_guess(12'h000, 1'b1, s);
        do_guess(12'h000, 1'b1, s);
        check("lose_early", lose, 0);
        do_guess(12'h000, 1'b1, s);
        check("lose_set", lose, 1);
        check("lose_attempts", attempts, 3);
        check("lose_active", game_active, 0);
        do_guess(12'h000, 1'b0, s);

        // Abort: new_game sampled 5 edges after the submit
        start_game(1'b1, {3'd1, 3'd1, 3'd1, 3'd1}, s);
        {guess_three, guess_two, guess_one, guess_zero} = {3'd1, 3'd1, 3'd1, 3'd1};
        submit = 1'b1;
        @(negedge clk);
        submit = 1'b0;
        repeat (4) @(negedge clk);
        rv0 = rv_count;
        start_game(1'b1, {3'd5, 3'd6, 3'd7, 3'd1}, s);
        do_guess({3'd1, 3'd1, 3'd1, 3'd1}, 1'b1, s);
        check("abort_rv_count", rv_count - rv0, 1);
        check("abort_attempts", attempts, 1);

        // Submit while busy is dropped
        start_game(1'b1, {3'd0, 3'd3, 3'd5, 3'd7}, s);
        a0 = attempts; rv0 = rv_count;
        g = {3'd7, 3'd5, 3'd3, 3'd0};
        {guess_three, guess_two, guess_one, guess_zero} = g;
        exp_q.push_back(score(s, g));
        submit = 1'b1;
        @(negedge clk);
        submit = 1'b0;
        repeat (3) @(negedge clk);
        {guess_three, guess_two, guess_one, guess_zero} = s;
        submit = 1'b1;
        @(negedge clk);
        submit = 1'b0;
        repeat (30) @(negedge clk);
        check("busy_drop_rv", rv_count - rv0, 1);
        check("busy_drop_attempts", attempts, a0 + 4'd1);
        check("busy_drop_win", win, 0);

        for (int i = 0; i < 6; i++) begin
            start_game(i[0], 12'($urandom), s);
            g  = 12'($urandom);
            g2 = 12'($urandom);
            r  = score(s, g);
            do_guess(g, 1'b1, s);
            do_guess(g2, r[5:3] != 3'd4, s);
        end

        // Asynchronous reset during an evaluation
        start_game(1'b1, {3'd2, 3'd4, 3'd6, 3'd0}, s);
        submit = 1'b1;
        @(negedge clk);
        submit = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", {busy, result_valid, attempts, win, lose, game_active}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (16) @(negedge clk);
        check("post_reset_idle", {busy, game_active}, 0);

        check("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
